mdc_delay_commutator: RTL and testbench
=======================================

Name: mdc_delay_commutator

Overview:
- Parametrised delay-commutator for the pipelined MDC IFFT/FFT datapath (two parallel complex lanes, upper and lower).
- Combines a lower-input delay line, a swap/bypass switch driven by an internal phase counter, and an upper-output delay line.
- Reorders each 2*DEPTH-sample block for the next butterfly stage.
- Replaces the external control_signal of the fixed 4-point stage commutator with self-sequenced control; one instance per stage, DEPTH set per stage (16, 8, 4, 2, 1 for 32-point).

Parameters:
- DW, 14, width of each real/imag component, signed two's complement (S4.9 in the current IFFT).
- DEPTH, 4, delay length in accepted samples; power of two, >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- sync_clr  in  1  synchronous frame restart; clears phase and fill state, keeps delay contents.
- in_valid  in  1  sample-accept strobe; no backpressure.
- UI_real, UI_imag  in  DW each  upper-lane input.
- LI_real, LI_imag  in  DW each  lower-lane input.
- out_valid  out  1  output pair valid.
- UO_real, UO_imag  out  DW each  upper-lane output, registered.
- LO_real, LO_imag  out  DW each  lower-lane output, registered.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst; all state changes on the rising edge of clk.
- Reset values:
  - All outputs are 0.
  - Phase counter p = 0; fill counter = 0.
  - Both delay lines are cleared to 0.
- Phase counter and switch:
  - p is log2(DEPTH)+1 bits and increments modulo 2*DEPTH on each accepted sample (in_valid=1).
  - sel = MSB of p; for DEPTH=1, sel = p.
  - Let DLo = the lower delay line output (the LI value accepted DEPTH samples earlier).
  - sel=0, bypass: sw_u = UI, sw_l = DLo.
  - sel=1, swap: sw_u = DLo, sw_l = UI.
- Delay lines:
  - Lower delay line: DEPTH entries, 2*DW wide, shifts in LI only when in_valid=1.
  - Upper delay line: DEPTH entries, shifts in sw_u only when in_valid=1.
- Output registers, on an accepted sample:
  - UO <= upper delay line output; LO <= sw_l.
  - out_valid <= 1 only if the fill counter is already >= DEPTH before this sample; otherwise out_valid <= 0.
- Fill counter: saturating count of accepted samples, reaching DEPTH.
- Stall: when in_valid=0, the counter, both delay lines, UO and LO hold their values, and out_valid <= 0 on the next edge.
- Latency:
  - DEPTH accepted samples plus 1 clock.
  - The first out_valid appears one cycle after the (DEPTH+1)th accepted sample.
- Data ordering: with upper inputs a_k and lower inputs b_k, the output pairs are (a0,aD), (a1,aD+1), …, (aD-1,a2D-1), (b0,bD), …, and the pattern continues per block.
- Arithmetic: none. Values pass bit-exact; no sign extension or rounding.
- sync_clr:
  - p and fill are cleared to 0; out_valid <= 0 that cycle.
  - The sample present in the same cycle is accepted as phase 0 with fill 0.
  - rst has priority over sync_clr.
- Reset mid-frame: all in-flight samples are discarded; output restarts after a fresh DEPTH-sample fill.
- DEPTH=1: the delay lines degenerate to single registers; same rules apply.

Optional Feature:
- Macro MDC_COMMUTATOR_SOF_EN.
- Defined: adds output port out_sof (1 bit, reset 0), registered alongside out_valid. out_sof is 1 only on the valid output pair whose source sample had p == DEPTH, i.e. the first pair (a0,aD) of each block.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fft_pkg:
  - DW default.
  - Packed complex typedef cplx_t {real, imag}.
  - Function clog2 for counter widths.
- One natural sub-module, cplx_delay_line: parameters DEPTH and width, enable input, synchronous clear. Instantiated twice.

Test Plan:
- Continuous stream, DEPTH=4:
  - Stimulus: reset, then in_valid=1 with UI = 0..15 and LI = 100..115.
  - out_valid rises one cycle after the 5th sample.
  - Pairs in order: (0,4), (1,5), (2,6), (3,7), (100,104), (101,105), (102,106), (103,107), (8,12), …
- Stalls:
  - Same stream, in_valid deasserted for 3 cycles after the 6th sample.
  - UO/LO hold during the stall; out_valid is 0 for those cycles; the pair sequence is unchanged.
- DEPTH=1, UI = 1,2,3,4 and LI = 11,12,13,14:
  - Pairs: (1,2), (11,12), (3,4), (13,14).
- Restart and reset mid-frame:
  - sync_clr pulse after the 6th sample → out_valid stays low until 4 further samples are accepted, then the pairs follow the new-frame phase.
  - rst pulse mid-frame → all outputs 0; the same recovery sequence follows.
- Sign and extreme values:
  - UI = -8192 (0x2000) and LI = 8191 are passed bit-exact through both paths.
- With MDC_COMMUTATOR_SOF_EN, DEPTH=4:
  - out_sof is high exactly on pairs (0,4) and (8,12), and on no other cycle.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the MDC FFT/IFFT datapath: default component
// width, the packed complex sample type and a constant-foldable log2
// helper used to size counters.
package fft_pkg;

  // Default component width (S4.9 in the current IFFT).
  localparam int FFT_DW = 14;

  // Packed complex sample at the default width; real part in the upper half.
  // Fields are re/im because "real" is a reserved word.
  typedef struct packed {
    logic [FFT_DW-1:0] re;
    logic [FFT_DW-1:0] im;
  } cplx_t;

  // Ceiling log2; returns 0 for values <= 1 so DEPTH=1 yields a 1-bit phase.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cplx_delay_line.sv
// Enable-gated shift-register delay line for packed complex samples.
// A value shifted in appears on q exactly DEPTH enabled cycles later.
// clr is a synchronous clear of every stage and has priority over en.
module cplx_delay_line
  import fft_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2 * FFT_DW
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // tap[0] is the input; tap[i+1] is the output of stage i.
  logic [WIDTH-1:0] tap [DEPTH+1];

  assign tap[0] = d;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] stage_reg;

    // Each stage takes its predecessor only on an accepted sample.
    always_ff @(posedge clk) begin
      if (clr) begin
        stage_reg <= '0;
      end else if (en) begin
        stage_reg <= tap[gi];
      end
    end

    assign tap[gi+1] = stage_reg;
  end

  assign q = tap[DEPTH];

endmodule

// File: rtl/mdc_delay_commutator.sv
// Delay-commutator for one stage of the two-lane MDC FFT/IFFT pipeline.
// The lower lane is delayed by DEPTH samples, then a swap/bypass switch
// driven by an internal phase counter pairs it with the upper lane, and
// the switch's upper output is delayed again by DEPTH samples. The net
// effect reorders every 2*DEPTH-sample block for the next butterfly.
// Optional macro MDC_COMMUTATOR_SOF_EN adds the out_sof port, flagging the
// first output pair of each block.
module mdc_delay_commutator
  import fft_pkg::*;
#(
  parameter int DW    = FFT_DW,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sync_clr,
  input  logic          in_valid,
  input  logic [DW-1:0] UI_real,
  input  logic [DW-1:0] UI_imag,
  input  logic [DW-1:0] LI_real,
  input  logic [DW-1:0] LI_imag,
  output logic          out_valid,
  output logic [DW-1:0] UO_real,
  output logic [DW-1:0] UO_imag,
  output logic [DW-1:0] LO_real,
  output logic [DW-1:0] LO_imag
`ifdef MDC_COMMUTATOR_SOF_EN
  ,
  output logic          out_sof
`endif
);

  // Phase counts modulo 2*DEPTH, so its MSB is the swap select; the fill
  // counter shares the width because it saturates at DEPTH.
  localparam int PW = clog2(DEPTH) + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } lane_t;

  lane_t ui;
  lane_t li;
  lane_t dlo;
  lane_t du;
  lane_t sw_u;
  lane_t sw_l;
  lane_t uo_reg;
  lane_t lo_reg;

  logic [PW-1:0] p_reg;
  logic [PW-1:0] fill_reg;
  logic [PW-1:0] p_cur;
  logic [PW-1:0] fill_cur;
  logic          sel;
  logic          full;
  logic          out_valid_reg;

  assign ui.re = UI_real;
  assign ui.im = UI_imag;
  assign li.re = LI_real;
  assign li.im = LI_imag;

  // A frame restart makes the sample of the same cycle phase 0 with an
  // empty fill, so the switch must already see the cleared values.
  always_comb begin
    p_cur    = sync_clr ? '0 : p_reg;
    fill_cur = sync_clr ? '0 : fill_reg;
    sel      = p_cur[PW-1];
    full     = (fill_cur == DEPTH_P);
    if (sel) begin
      sw_u = dlo;
      sw_l = ui;
    end else begin
      sw_u = ui;
      sw_l = dlo;
    end
  end

  // Lower-lane input delay; only rst clears it, a frame restart keeps it.
  cplx_delay_line #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DW)
  ) u_lower_delay (
    .clk (clk),
    .clr (rst),
    .en  (in_valid),
    .d   (li),
    .q   (dlo)
  );

  // Upper-lane output delay fed from the switch.
  cplx_delay_line #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DW)
  ) u_upper_delay (
    .clk (clk),
    .clr (rst),
    .en  (in_valid),
    .d   (sw_u),
    .q   (du)
  );

`ifdef MDC_COMMUTATOR_SOF_EN
  logic sof_reg;

  // Flags the pair produced by the sample at phase DEPTH: the block's first pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      sof_reg <= 1'b0;
    end else if (in_valid) begin
      sof_reg <= full && (p_cur == DEPTH_P);
    end else begin
      sof_reg <= 1'b0;
    end
  end

  assign out_sof = sof_reg;
`endif

  // Phase/fill sequencing and output registers; outputs hold across stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg         <= '0;
      fill_reg      <= '0;
      uo_reg        <= '0;
      lo_reg        <= '0;
      out_valid_reg <= 1'b0;
    end else if (in_valid) begin
      p_reg         <= p_cur + PW'(1);
      fill_reg      <= full ? fill_cur : fill_cur + PW'(1);
      uo_reg        <= du;
      lo_reg        <= sw_l;
      out_valid_reg <= full;
    end else begin
      if (sync_clr) begin
        p_reg    <= '0;
        fill_reg <= '0;
      end
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign UO_real   = uo_reg.re;
  assign UO_imag   = uo_reg.im;
  assign LO_real   = lo_reg.re;
  assign LO_imag   = lo_reg.im;

endmodule

// File: tb/tb_mdc_delay_commutator.sv
// Bench for mdc_delay_commutator: drives a DEPTH=4 and a DEPTH=1 instance
// with the same stimulus and checks both every cycle against a block-order
// model (pairs computed from sample indices within the current frame),
// plus literal expected pairs for the directed scenarios.
module tb_mdc_delay_commutator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_rst = 1'b1;
  logic        d_clr = 1'b0;
  logic        d_vld = 1'b0;
  logic [27:0] d_u   = '0;
  logic [27:0] d_l   = '0;

  logic [13:0] uo_re4, uo_im4, lo_re4, lo_im4, uo_re1, uo_im1, lo_re1, lo_im1;
  logic        ov4, ov1;
  logic        sof4, sof1;

  logic [27:0] duo [2];
  logic [27:0] dlo [2];
  logic        dv  [2];
  logic        dsof[2];

  mdc_delay_commutator #(.DW(14), .DEPTH(4)) dut4 (
    .clk(clk), .rst(d_rst), .sync_clr(d_clr), .in_valid(d_vld),
    .UI_real(d_u[27:14]), .UI_imag(d_u[13:0]),
    .LI_real(d_l[27:14]), .LI_imag(d_l[13:0]),
    .out_valid(ov4),
    .UO_real(uo_re4), .UO_imag(uo_im4), .LO_real(lo_re4), .LO_imag(lo_im4)
`ifdef MDC_COMMUTATOR_SOF_EN
    , .out_sof(sof4)
`endif
  );

  mdc_delay_commutator #(.DW(14), .DEPTH(1)) dut1 (
    .clk(clk), .rst(d_rst), .sync_clr(d_clr), .in_valid(d_vld),
    .UI_real(d_u[27:14]), .UI_imag(d_u[13:0]),
    .LI_real(d_l[27:14]), .LI_imag(d_l[13:0]),
    .out_valid(ov1),
    .UO_real(uo_re1), .UO_imag(uo_im1), .LO_real(lo_re1), .LO_imag(lo_im1)
`ifdef MDC_COMMUTATOR_SOF_EN
    , .out_sof(sof1)
`endif
  );

`ifndef MDC_COMMUTATOR_SOF_EN
  assign sof4 = 1'b0;
  assign sof1 = 1'b0;
`endif

  assign duo[0]  = {uo_re4, uo_im4};
  assign dlo[0]  = {lo_re4, lo_im4};
  assign dv[0]   = ov4;
  assign dsof[0] = sof4;
  assign duo[1]  = {uo_re1, uo_im1};
  assign dlo[1]  = {lo_re1, lo_im1};
  assign dv[1]   = ov1;
  assign dsof[1] = sof1;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  // Per instance: samples accepted since the last rst/sync_clr, indexed n.
  // For n >= D the pair is (a[n-D], a[n]) in the odd half of a block,
  // otherwise (b[n-2D], b[n-D]); the first pair of a block has n%2D == D.
  logic [27:0] ah [2][1024];
  logic [27:0] bh [2][1024];
  int          nacc [2];
  bit          ev   [2];
  bit          esof [2];
  bit          known[2];
  bit          stale[2];
  logic [27:0] euo  [2];
  logic [27:0] elo  [2];
  bit          started = 1'b0;

  task automatic model_step(input int m, input int dep);
    int n;
    if (d_rst) begin
      nacc[m] = 0; ev[m] = 1'b0; esof[m] = 1'b0;
      euo[m] = '0; elo[m] = '0; known[m] = 1'b1; stale[m] = 1'b0;
      started = 1'b1;
      return;
    end
    if (d_clr) begin
      nacc[m] = 0;
      stale[m] = 1'b1;
    end
    ev[m] = 1'b0;
    esof[m] = 1'b0;
    if (!d_vld) return;
    n = nacc[m];
    ah[m][n] = d_u;
    bh[m][n] = d_l;
    nacc[m] = n + 1;
    if (n < dep) begin
      // Filling: data comes from delay contents; zero only if freshly reset.
      if (stale[m]) begin
        known[m] = 1'b0;
      end else begin
        euo[m] = '0; elo[m] = '0; known[m] = 1'b1;
      end
    end else begin
      if (((n / dep) % 2) == 1) begin
        euo[m] = ah[m][n-dep];
        elo[m] = ah[m][n];
      end else begin
        euo[m] = bh[m][n-2*dep];
        elo[m] = bh[m][n-dep];
      end
      ev[m]    = 1'b1;
      esof[m]  = ((n % (2 * dep)) == dep);
      known[m] = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input int dep, input logic [27:0] act, input logic [27:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s depth=%0d t=%0t got=%h expected=%h", nm, dep, $time, act, exp_v);
    end
  endtask

  // Recorded real-part pairs {UO_real, LO_real} of each valid output.
  logic [27:0] p4[$];
  logic [27:0] p1[$];
  int          s4[$];

  // Single compare process: all outputs of both instances, every cycle.
  always @(negedge clk) begin
    if (started) begin
      for (int m = 0; m < 2; m++) begin
        chk("out_valid", (m == 0) ? 4 : 1, {27'b0, dv[m]}, {27'b0, ev[m]});
        if (known[m]) begin
          chk("UO", (m == 0) ? 4 : 1, duo[m], euo[m]);
          chk("LO", (m == 0) ? 4 : 1, dlo[m], elo[m]);
        end
`ifdef MDC_COMMUTATOR_SOF_EN
        chk("out_sof", (m == 0) ? 4 : 1, {27'b0, dsof[m]}, {27'b0, esof[m]});
`endif
      end
      if (dv[0]) begin
        if (dsof[0]) s4.push_back(p4.size());
        p4.push_back({duo[0][27:14], dlo[0][27:14]});
      end
      if (dv[1]) p1.push_back({duo[1][27:14], dlo[1][27:14]});
    end
  end

  // ---------------- literal expectations ----------------
  task automatic pin(input int which, input int idx, input int ur, input int lr);
    logic [27:0] exp_v;
    exp_v = {14'(ur), 14'(lr)};
    checks++;
    if ((which == 4 && idx >= p4.size()) || (which == 1 && idx >= p1.size())) begin
      errors++;
      $display("FAIL pair_missing depth=%0d idx=%0d got=none expected=%h", which, idx, exp_v);
    end else if (((which == 4) ? p4[idx] : p1[idx]) !== exp_v) begin
      errors++;
      $display("FAIL pair_literal depth=%0d idx=%0d got=%h expected=%h", which, idx,
               (which == 4) ? p4[idx] : p1[idx], exp_v);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp_v);
    end
  endtask

  task automatic pin_zero(input string nm);
    chk(nm, 4, {ov4, uo_re4, uo_im4, lo_re4[13:1]}, 28'd0);
    chk(nm, 4, {lo_re4[0], lo_im4, 13'd0}, 28'd0);
    chk(nm, 1, {ov1, uo_re1, uo_im1, lo_re1[13:1]}, 28'd0);
    chk(nm, 1, {lo_re1[0], lo_im1, 13'd0}, 28'd0);
  endtask

  // ---------------- stimulus ----------------
  // One clock: inputs set just after the falling edge, model advanced at
  // the rising edge, return after the falling-edge compare has run.
  task automatic cyc(input bit r, input bit c, input bit v,
                     input int ur, input int ui, input int lr, input int li);
    d_rst = r; d_clr = c; d_vld = v;
    d_u = {14'(ur), 14'(ui)};
    d_l = {14'(lr), 14'(li)};
    @(posedge clk);
    model_step(0, 4);
    model_step(1, 1);
    @(negedge clk);
    #1;
  endtask

  task automatic smp(input int k, input int bu, input int bl);
    cyc(1'b0, 1'b0, 1'b1, bu + k, -(bu + k) - 1, bl + k, 300 + bl + k);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 77, 77, 77, 77);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  int e4 [9][2] = '{'{0, 4}, '{1, 5}, '{2, 6}, '{3, 7},
                    '{100, 104}, '{101, 105}, '{102, 106}, '{103, 107}, '{8, 12}};
  int e1 [4][2] = '{'{1, 2}, '{11, 12}, '{3, 4}, '{13, 14}};
  int b;

  initial begin
    @(negedge clk);
    #1;
    do_reset();
    pin_zero("reset_state");

    // Continuous stream DEPTH=4 order.
    p4.delete(); p1.delete(); s4.delete();
    for (int k = 0; k < 16; k++) smp(k, 0, 100);
    idle(); idle();
    for (int i = 0; i < 9; i++) pin(4, i, e4[i][0], e4[i][1]);
    chk_int("pairs4_count_stream", p4.size(), 12);
`ifdef MDC_COMMUTATOR_SOF_EN
    chk_int("sof_count", s4.size(), 2);
    if (s4.size() == 2) begin
      chk_int("sof_first_idx", s4[0], 0);
      chk_int("sof_second_idx", s4[1], 8);
    end
`endif

    // DEPTH=1 order.
    do_reset();
    p1.delete();
    for (int k = 1; k <= 5; k++) cyc(1'b0, 1'b0, 1'b1, k, -k, 10 + k, -10 - k);
    idle();
    for (int i = 0; i < 4; i++) pin(1, i, e1[i][0], e1[i][1]);

    // Stall of 3 cycles after the 6th sample; order unchanged.
    do_reset();
    p4.delete();
    for (int k = 0; k < 16; k++) begin
      smp(k, 0, 100);
      if (k == 5) begin
        idle(); idle(); idle();
      end
    end
    idle();
    for (int i = 0; i < 9; i++) pin(4, i, e4[i][0], e4[i][1]);
    chk_int("pairs4_count_stall", p4.size(), 12);

    // sync_clr alone after the 6th sample, then a new frame.
    do_reset();
    for (int k = 0; k < 6; k++) smp(k, 0, 100);
    b = p4.size();
    cyc(1'b0, 1'b1, 1'b0, 77, 77, 77, 77);
    for (int k = 0; k < 12; k++) smp(k, 20, 120);
    pin(4, b, 20, 24);
    pin(4, b + 4, 120, 124);
    chk_int("pairs4_count_after_clr", p4.size() - b, 8);

    // sync_clr together with a sample: that sample is phase 0.
    b = p4.size();
    cyc(1'b0, 1'b1, 1'b1, 40, -41, 140, 440);
    for (int k = 1; k < 8; k++) smp(k, 40, 140);
    pin(4, b, 40, 44);

    // rst mid-frame with a sample present: sample discarded, outputs zero.
    for (int k = 0; k < 7; k++) smp(k, 60, 160);
    cyc(1'b1, 1'b0, 1'b1, 99, 99, 99, 99);
    pin_zero("reset_mid_frame");
    b = p4.size();
    for (int k = 0; k < 9; k++) smp(k, 50, 150);
    pin(4, b, 50, 54);
    chk_int("pairs4_count_after_rst", p4.size() - b, 5);

    // Extreme values pass bit-exact on both paths.
    do_reset();
    b = p4.size();
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'b0, 1'b1, -8192, 8191, 8191, -8192);
    pin(4, b, -8192, -8192);
    pin(4, b + 4, 8191, 8191);

    // Mixed random traffic with occasional restarts.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
          int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)),
          int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
